// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode constants and fetch FSM state encoding for the
//                single-issue MIPS-subset core (fetch + decode controller).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_t;

    // Extract the primary opcode field of an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC selection: sequential (pc+4), taken
//                beq (pc+4 + sext(imm)<<2) or j (pseudo-direct target).
//                Jump has priority over branch.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [25:0]       instr_idx,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_jmp_tgt;

    // All arithmetic wraps modulo 2^ADDR_W
    assign w_pc4    = pc_cur + ADDR_W'(4);
    assign w_br_off = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
    assign w_br_tgt = w_pc4 + w_br_off;

    // With a 28-bit address space the jump field covers the whole range
    generate
        if (ADDR_W > 28) begin : g_jmp_region
            assign w_jmp_tgt = {w_pc4[ADDR_W-1:28], instr_idx, 2'b00};
        end else begin : g_jmp_full
            assign w_jmp_tgt = {instr_idx, 2'b00};
        end
    endgenerate

    // Priority select: jump, then taken branch, then sequential
    always_comb begin
        next_pc = w_pc4;
        if (jump) begin
            next_pc = w_jmp_tgt;
        end else if (branch && zero) begin
            next_pc = w_br_tgt;
        end
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage. Owns the PC, reads instruction memory over a
//                req/ack handshake, presents each word to decode over a
//                valid/ready handshake and redirects on j / taken beq at the
//                retire point. Stops permanently on the halt opcode.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]       HALT_OP  = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_out;
    logic [31:0]       r_instr;
    logic              r_req;
    logic              r_valid;
    logic              r_halted;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_is_halt;

    // Next PC is computed from the presented instruction and its address
    pc_next_calc #(
        .ADDR_W    (ADDR_W)
    ) u_pc_next_calc (
        .pc_cur    (r_pc_out),
        .instr_idx (r_instr[25:0]),
        .branch    (branch),
        .jump      (jump),
        .zero      (zero),
        .next_pc   (w_next_pc)
    );

    assign w_is_halt = (opcode_of(r_instr) == HALT_OP);

    // Fetch FSM with all outputs registered; ack and controller inputs are
    // only looked at in the state that owns them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FETCH_IDLE;
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_instr  <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    r_req   <= 1'b1;
                    r_state <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (imem_ack) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_req    <= 1'b0;
                        r_state  <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= FETCH_HALT;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= FETCH_REQ;
                        end
                    end
                end
                FETCH_HALT: begin
                    r_req    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc_out;
    assign halted      = r_halted;

endmodule : instr_fetch
`default_nettype wire
